// File: rtl/irq_controller.sv
// irq_controller: fixed-priority interrupt controller with a claim/complete
// register interface on the load/store bus.
//
// Ports:
//   clk, rst (async, active-low)      - clock and reset
//   irq_src[NUM_SRC]                  - raw interrupt lines (asynchronous)
//   cs, wr, mask, addr, data_wr       - bus request
//   data_rd, valid                    - registered one-cycle bus response
//   interrupt                         - registered request to the CSR unit
//
// Registers (word offsets from BASE_ADDR):
//   0x00 PENDING (RO), 0x04 ENABLE, 0x08 EDGE, 0x0C CLAIM (rd=claim, wr=complete)
module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cs,
    input  logic               wr,
    input  logic [3:0]         mask,
    input  logic [31:0]        addr,
    input  logic [31:0]        data_wr,
    output logic [31:0]        data_rd,
    output logic               valid,
    output logic               interrupt
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_edge;
    logic [4:0]         r_in_service;
    logic [31:0]        r_data_rd;
    logic               r_valid;
    logic               r_irq;

    logic [31:0]        w_offset;
    logic               w_in_win;
    logic               w_rd;
    logic               w_wr;
    logic               w_sel_en;
    logic               w_sel_edge;
    logic               w_sel_claim;
    logic               w_claim_ok;
    logic [31:0]        w_bm;
    logic [31:0]        w_rdata;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_svc;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_win_oh;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [4:0]         w_win_id;
    logic               w_any;
    logic               w_unused;

    // Address decode; the low two address bits are ignored.
    assign w_offset    = addr - BASE_ADDR;
    assign w_in_win    = (w_offset[31:4] == 28'd0);
    assign w_rd        = cs & ~wr;
    assign w_wr        = cs & wr;
    assign w_sel_en    = w_in_win && (w_offset[3:2] == 2'd1);
    assign w_sel_edge  = w_in_win && (w_offset[3:2] == 2'd2);
    assign w_sel_claim = w_in_win && (w_offset[3:2] == 2'd3);

    assign w_bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

    assign w_unused = &{1'b0, w_offset[1:0], data_wr, w_bm};

    assign w_rise = r_sync2 & ~r_prev;

    // The source currently in service is not eligible for arbitration.
    always_comb begin
        w_svc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_svc[i] = (r_in_service == 5'(i + 1));
        end
    end

    assign w_elig = r_pending & r_enable & ~w_svc;
    assign w_any  = |w_elig;

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_win_id = '0;
        w_win_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id    = 5'(i + 1);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Next-state logic for the claim/complete sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_claim_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd && w_sel_claim && w_any) begin
                    w_state_nxt = S_ACTIVE;
                    w_claim_ok  = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_wr && w_sel_claim &&
                    (data_wr[4:0] == r_in_service)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Claiming an edge source consumes its pending bit; a new rising edge
    // in the same cycle re-sets it (set wins over clear).
    assign w_clr = w_claim_ok ? (w_win_oh & r_edge) : '0;

    assign w_pend_nxt = (r_edge & ((r_pending & ~w_clr) | w_rise)) |
                        (~r_edge & r_sync2);

    // Read data mux.
    always_comb begin
        w_rdata = '0;
        if (w_rd && w_in_win) begin
            case (w_offset[3:2])
                2'd0: w_rdata = 32'(r_pending);
                2'd1: w_rdata = 32'(r_enable);
                2'd2: w_rdata = 32'(r_edge);
                2'd3: w_rdata = w_claim_ok ? 32'(w_win_id) : 32'd0;
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prev       <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_edge       <= '0;
            r_in_service <= '0;
            r_data_rd    <= '0;
            r_valid      <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_sync1   <= irq_src;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pending <= w_pend_nxt;
            if (w_wr && w_sel_en) begin
                r_enable <= (r_enable & ~w_bm[NUM_SRC-1:0]) |
                            (data_wr[NUM_SRC-1:0] & w_bm[NUM_SRC-1:0]);
            end
            if (w_wr && w_sel_edge) begin
                r_edge <= (r_edge & ~w_bm[NUM_SRC-1:0]) |
                          (data_wr[NUM_SRC-1:0] & w_bm[NUM_SRC-1:0]);
            end
            if (w_claim_ok) begin
                r_in_service <= w_win_id;
            end else if (r_state == S_ACTIVE && w_state_nxt == S_IDLE) begin
                r_in_service <= '0;
            end
            r_data_rd <= w_rdata;
            r_valid   <= cs;
            r_irq     <= (r_state == S_IDLE) && w_any;
        end
    end

    assign data_rd   = r_data_rd;
    assign valid     = r_valid;
    assign interrupt = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_controller;

    localparam logic [31:0] A_PEND  = 32'h0000_0400;
    localparam logic [31:0] A_EN    = 32'h0000_0404;
    localparam logic [31:0] A_EDGE  = 32'h0000_0408;
    localparam logic [31:0] A_CLAIM = 32'h0000_040C;
    localparam logic [31:0] A_OTHER = 32'h0000_0410;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_src;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        valid;
    logic        interrupt;

    int          n_tests;
    int          n_fail;
    logic [31:0] rdat;

    irq_controller #(
        .NUM_SRC   (8),
        .BASE_ADDR (32'h0000_0400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .cs        (cs),
        .wr        (wr),
        .mask      (mask),
        .addr      (addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .valid     (valid),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cs   = 1'b1;
        wr   = 1'b0;
        mask = 4'h0;
        addr = a;
        @(negedge clk);
        cs = 1'b0;
        d  = data_rd;
        check("rd_valid", 32'(valid), 32'd1);
    endtask

    task automatic wrr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        @(negedge clk);
        cs      = 1'b1;
        wr      = 1'b1;
        mask    = m;
        addr    = a;
        data_wr = d;
        @(negedge clk);
        cs = 1'b0;
        wr = 1'b0;
        check("wr_valid", 32'(valid), 32'd1);
        check("wr_data0", data_rd, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        irq_src = 8'hFF;
        cs      = 1'b0;
        wr      = 1'b0;
        mask    = 4'h0;
        addr    = '0;
        data_wr = '0;

        // Reset held with all lines high.
        cyc(4);
        check("rst_int", 32'(interrupt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data_rd, 32'd0);
        rst = 1'b1;
        cyc(5);
        check("en0_int", 32'(interrupt), 32'd0);
        rd(A_PEND, rdat);
        check("pend_level", rdat, 32'h0000_00FF);
        irq_src = 8'h00;
        cyc(5);
        rd(A_PEND, rdat);
        check("pend_drop", rdat, 32'd0);

        // Single edge source, latency to interrupt.
        wrr(A_EDGE, 32'h0000_00FF, 4'hF);
        wrr(A_EN, 32'h0000_0004, 4'hF);
        @(negedge clk);
        irq_src = 8'h04;
        cyc(3);
        check("lat_int0", 32'(interrupt), 32'd0);
        cyc(1);
        check("lat_int1", 32'(interrupt), 32'd1);
        irq_src = 8'h00;
        rd(A_CLAIM, rdat);
        check("claim3", rdat, 32'd3);
        cyc(1);
        check("claim3_int", 32'(interrupt), 32'd0);
        wrr(A_CLAIM, 32'd3, 4'hF);
        cyc(2);
        check("cpl3_int", 32'(interrupt), 32'd0);
        rd(A_PEND, rdat);
        check("cpl3_pend", rdat, 32'd0);

        // Priority: sources 5 and 1 together.
        wrr(A_EN, 32'h0000_00FF, 4'hF);
        @(negedge clk);
        irq_src = 8'h22;
        cyc(5);
        irq_src = 8'h00;
        rd(A_CLAIM, rdat);
        check("prio_1st", rdat, 32'd2);
        wrr(A_CLAIM, 32'd2, 4'hF);
        rd(A_CLAIM, rdat);
        check("prio_2nd", rdat, 32'd6);
        wrr(A_CLAIM, 32'd6, 4'hF);
        rd(A_CLAIM, rdat);
        check("prio_3rd", rdat, 32'd0);

        // No nesting and wrong complete id.
        @(negedge clk);
        irq_src = 8'h02;
        cyc(5);
        irq_src = 8'h00;
        rd(A_CLAIM, rdat);
        check("nest_claim2", rdat, 32'd2);
        @(negedge clk);
        irq_src = 8'h01;
        cyc(5);
        irq_src = 8'h00;
        rd(A_CLAIM, rdat);
        check("nest_claim0", rdat, 32'd0);
        check("nest_int", 32'(interrupt), 32'd0);
        wrr(A_CLAIM, 32'd5, 4'hF);
        rd(A_CLAIM, rdat);
        check("wrong_cpl", rdat, 32'd0);
        cyc(1);
        check("wrong_int", 32'(interrupt), 32'd0);
        wrr(A_CLAIM, 32'd2, 4'hF);
        cyc(1);
        check("cpl2_int", 32'(interrupt), 32'd1);
        rd(A_CLAIM, rdat);
        check("claim1", rdat, 32'd1);
        wrr(A_CLAIM, 32'd1, 4'hF);

        // Level mode with byte-masked enable writes.
        wrr(A_EDGE, 32'h0000_0000, 4'hF);
        wrr(A_EN, 32'hFFFF_FF00, 4'hF);
        rd(A_EN, rdat);
        check("en_clear", rdat, 32'd0);
        wrr(A_EN, 32'hFFFF_FF08, 4'b0001);
        wrr(A_EN, 32'h0000_00FF, 4'b1110);
        rd(A_EN, rdat);
        check("en_mask", rdat, 32'h0000_0008);
        @(negedge clk);
        irq_src = 8'h08;
        cyc(5);
        check("lvl_int", 32'(interrupt), 32'd1);
        rd(A_CLAIM, rdat);
        check("lvl_claim", rdat, 32'd4);
        cyc(1);
        check("lvl_act_int", 32'(interrupt), 32'd0);
        wrr(A_CLAIM, 32'd4, 4'hF);
        cyc(1);
        check("lvl_reassert", 32'(interrupt), 32'd1);
        irq_src = 8'h00;
        cyc(5);
        rd(A_PEND, rdat);
        check("lvl_pend0", rdat, 32'd0);
        check("lvl_int0", 32'(interrupt), 32'd0);

        // Back-to-back reads: ENABLE then an unmapped offset.
        @(negedge clk);
        cs   = 1'b1;
        wr   = 1'b0;
        addr = A_EN;
        @(negedge clk);
        addr = A_OTHER;
        check("b2b_v1", 32'(valid), 32'd1);
        check("b2b_d1", data_rd, 32'h0000_0008);
        @(negedge clk);
        cs = 1'b0;
        check("b2b_v2", 32'(valid), 32'd1);
        check("b2b_d2", data_rd, 32'd0);
        @(negedge clk);
        check("b2b_v3", 32'(valid), 32'd0);

        // Reset while a source is in service.
        wrr(A_EDGE, 32'h0000_00FF, 4'hF);
        wrr(A_EN, 32'h0000_00FF, 4'hF);
        @(negedge clk);
        irq_src = 8'h40;
        cyc(5);
        irq_src = 8'h00;
        rd(A_CLAIM, rdat);
        check("pre_rst_claim", rdat, 32'd7);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        check("mid_rst_int", 32'(interrupt), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", data_rd, 32'd0);
        rst = 1'b1;
        cyc(2);
        rd(A_EN, rdat);
        check("post_rst_en", rdat, 32'd0);
        wrr(A_EDGE, 32'h0000_00FF, 4'hF);
        wrr(A_EN, 32'h0000_00FF, 4'hF);
        @(negedge clk);
        irq_src = 8'h10;
        cyc(5);
        irq_src = 8'h00;
        check("post_rst_int", 32'(interrupt), 32'd1);
        rd(A_CLAIM, rdat);
        check("post_rst_claim", rdat, 32'd5);
        wrr(A_CLAIM, 32'd5, 4'hF);
        rd(A_CLAIM, rdat);
        check("post_rst_empty", rdat, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
